// File: rtl/uferi_pkg.sv
// Shared types and constants for the UART command sequencer.
package uferi_pkg;

  // 3-bit command code carried in the packet header
  typedef enum logic [2:0] {
    CMD_0 = 3'd0,
    CMD_1 = 3'd1,
    CMD_2 = 3'd2,
    CMD_3 = 3'd3,
    CMD_4 = 3'd4,
    CMD_5 = 3'd5,
    CMD_6 = 3'd6,
    CMD_7 = 3'd7
  } cmd_e;

  // Sequencer state encoding
  typedef logic [2:0] seq_state_e;
  localparam seq_state_e ST_IDLE  = 3'd0;
  localparam seq_state_e ST_HDR   = 3'd1;
  localparam seq_state_e ST_PAY   = 3'd2;
  localparam seq_state_e ST_DRAIN = 3'd3;
  localparam seq_state_e ST_ISSUE = 3'd4;
  localparam seq_state_e ST_WAIT  = 3'd5;
  localparam seq_state_e ST_TX    = 3'd6;

  // Sticky error code reported alongside err_pulse
  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_OVF  = 2'b01,
    ERR_TMO  = 2'b10
  } err_e;

  // Header nibble layout
  localparam int unsigned HDR_PAY_BIT = 3;
  localparam int unsigned HDR_CMD_MSB = 2;
  localparam int unsigned HDR_CMD_LSB = 0;

  // Number of nibbles needed to carry a w-bit word
  function automatic int unsigned nib_count(input int unsigned w);
    return (w + 3) / 4;
  endfunction

  localparam int unsigned NIB_N = nib_count(42);

endpackage

// File: rtl/cmd_seq_nib_ser.sv
// Serialises a DATA_W word into nibbles, MSB nibble first, over valid/ready.
module cmd_seq_nib_ser
  import uferi_pkg::*;
#(
  parameter int unsigned DATA_W = 42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [3:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  localparam int unsigned NN = nib_count(DATA_W);
  localparam int unsigned SW = NN * 4;
  localparam int unsigned CW = $clog2(NN + 1);

  logic [SW-1:0] sh_q;
  logic [CW-1:0] left_q;
  logic          valid_q;
  logic          fire;

  assign fire     = valid_q && tx_ready;
  assign tx_data  = sh_q[SW-1 -: 4];
  assign tx_valid = valid_q;
  assign done     = fire && (left_q == CW'(1));

  // Load zero-padded word, then shift one nibble out per accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      sh_q    <= SW'(load_data);
      left_q  <= CW'(NN);
      valid_q <= 1'b1;
    end else if (fire) begin
      sh_q   <= sh_q << 4;
      left_q <= left_q - CW'(1);
      if (left_q == CW'(1)) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Assembles nibble packets from the RX FIFO into sreg_ctrl commands and
// streams readback data out as nibbles.
module cmd_sequencer
  import uferi_pkg::*;
#(
  parameter int unsigned DATA_W      = 42,
  parameter logic [7:0]  RDBACK_MASK = 8'h04,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              cmd_valid,
  output logic [2:0]        cmd,
  output logic [DATA_W-1:0] data2ctrl,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] data_out,
  output logic [3:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err_pulse,
  output logic [1:0]        err_code
);

  localparam int unsigned NN  = nib_count(DATA_W);
  localparam int unsigned PAD = NN * 4 - DATA_W;
  localparam int unsigned CW  = $clog2(NN + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
  // Bits of the first payload nibble that lie above the MSB of the word
  localparam logic [3:0]  PAD_MASK = 4'(8'hF0 >> PAD);

  seq_state_e        state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     pop_cnt_q, pop_cnt_d;
  logic [CW-1:0]     rcv_cnt_q, rcv_cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              skip_q, skip_d;
  logic              rd_pend_q;
  logic              armed_q;
  logic              err_pulse_q, err_pulse_d;
  err_e              err_code_q, err_code_d;
  logic              tmo_run;
  logic              tmo_evt;
  logic              ser_load;
  logic              ser_done;

  assign cmd       = cmd_q;
  assign data2ctrl = data_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_valid = (state_q == ST_ISSUE);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign tmo_run   = (state_q == ST_PAY) || (state_q == ST_DRAIN) || (state_q == ST_WAIT);
  // A pop or the post-command ready both count as forward progress
  assign tmo_evt   = fifo_rd_en || ((state_q == ST_WAIT) && !skip_q && cmd_ready);

  // Next-state, FIFO pop and error decode
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    pop_cnt_d   = pop_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    tmo_d       = '0;
    skip_d      = 1'b0;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    fifo_rd_en  = 1'b0;
    ser_load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        cmd_d     = cmd_e'(fifo_rdata[HDR_CMD_MSB:HDR_CMD_LSB]);
        data_d    = '0;
        pop_cnt_d = '0;
        rcv_cnt_d = '0;
        state_d   = fifo_rdata[HDR_PAY_BIT] ? ST_PAY : ST_ISSUE;
      end
      ST_PAY: begin
        fifo_rd_en = !fifo_empty && (pop_cnt_q < CW'(NN));
        if (fifo_rd_en) begin
          pop_cnt_d = pop_cnt_q + CW'(1);
        end
        if (rd_pend_q) begin
          data_d    = {data_q[DATA_W-5:0], fifo_rdata};
          rcv_cnt_d = rcv_cnt_q + CW'(1);
          if ((rcv_cnt_q == '0) && ((fifo_rdata & PAD_MASK) != 4'h0)) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_OVF;
            state_d     = ST_DRAIN;
          end else if (rcv_cnt_q == CW'(NN - 1)) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DRAIN: begin
        // pop_cnt keeps counting from PAY so exactly NN payload nibbles are consumed
        fifo_rd_en = !fifo_empty && (pop_cnt_q < CW'(NN));
        if (fifo_rd_en) begin
          pop_cnt_d = pop_cnt_q + CW'(1);
        end
        if (pop_cnt_q == CW'(NN)) begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          skip_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // First WAIT cycle ignores cmd_ready, which may still show the pre-accept idle
        if (!skip_q && cmd_ready) begin
          if (RDBACK_MASK[cmd_q]) begin
            ser_load = 1'b1;
            state_d  = ST_TX;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TX: begin
        if (ser_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_run && !tmo_evt) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_TMO;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_0;
      data_q      <= '0;
      pop_cnt_q   <= '0;
      rcv_cnt_q   <= '0;
      tmo_q       <= '0;
      skip_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      armed_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      pop_cnt_q   <= pop_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      tmo_q       <= tmo_d;
      skip_q      <= skip_d;
      rd_pend_q   <= fifo_rd_en;
      // Keeps fifo_rd_en low while reset is asserted
      armed_q     <= 1'b1;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  cmd_seq_nib_ser #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (data_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: directed packets, FIFO and sreg_ctrl models.
module tb_cmd_sequencer;

  localparam int unsigned DATA_W = 42;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [DATA_W-1:0] data;
  } exp_cmd_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        fifo_rdata;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [DATA_W-1:0] data2ctrl;
  logic              cmd_ready;
  logic [DATA_W-1:0] data_out;
  logic [3:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              err_pulse;
  logic [1:0]        err_code;

  int checks   = 0;
  int failures = 0;

  // FIFO model: stimulus owns wr_ptr/mem, the pop process owns rd_ptr
  logic [3:0] fifo_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pops   = 0;
  int         rdy_cnt;

  exp_cmd_t   exp_cmd_q[$];
  logic [3:0] exp_tx_q[$];
  logic [1:0] exp_err_q[$];

  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  cmd_sequencer #(
    .DATA_W      (DATA_W),
    .RDBACK_MASK (8'h04),
    .TIMEOUT_CYC (4096)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .data2ctrl  (data2ctrl),
    .cmd_ready  (cmd_ready),
    .data_out   (data_out),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .err_pulse  (err_pulse),
    .err_code   (err_code)
  );

  // FIFO pop: read data appears the cycle after fifo_rd_en; reset flushes
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rdata <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
      pops       <= pops + 1;
    end
  end

  // sreg_ctrl model: busy for 4 cycles after accepting a command
  always @(posedge clk) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      rdy_cnt   <= 0;
    end else if (cmd_valid && cmd_ready) begin
      cmd_ready <= 1'b0;
      rdy_cnt   <= 4;
    end else if (rdy_cnt > 0) begin
      rdy_cnt <= rdy_cnt - 1;
      if (rdy_cnt == 1) cmd_ready <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT output events against the scoreboard queues
  task automatic monitor_step();
    exp_cmd_t e;
    if (!rst_n) return;
    if (fifo_rd_en) check("pop_while_empty", 64'(fifo_empty), 64'd0);
    if (cmd_valid && cmd_ready) begin
      if (exp_cmd_q.size() == 0) check("cmd_unexpected", 64'(cmd_valid), 64'd0);
      else begin
        e = exp_cmd_q.pop_front();
        check("cmd_xfer", 64'({cmd, data2ctrl}), 64'({e.cmd, e.data}));
      end
    end
    if (tx_valid) begin
      if (exp_tx_q.size() == 0) check("tx_unexpected", 64'(tx_valid), 64'd0);
      else begin
        check("tx_nibble", 64'(tx_data), 64'(exp_tx_q[0]));
        if (tx_ready) void'(exp_tx_q.pop_front());
      end
    end
    if (err_pulse) begin
      if (exp_err_q.size() == 0) check("err_unexpected", 64'(err_pulse), 64'd0);
      else check("err_code", 64'(err_code), 64'(exp_err_q.pop_front()));
    end
  endtask

  task automatic push(input logic [3:0] n);
    fifo_mem[wr_ptr] = n;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && fifo_empty && cmd_ready && exp_cmd_q.size() == 0 &&
          exp_tx_q.size() == 0 && exp_err_q.size() == 0) return;
    end
    check({name, "_idle_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({fifo_rd_en, cmd_valid, cmd, data2ctrl, tx_data, tx_valid, busy,
                     err_pulse, err_code}), 64'd0);
  endtask

  initial begin
    logic [3:0] t1 [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h5};
    logic [3:0] t3 [11] = '{4'h3, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    int p0;
    bit seen;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    rst_n    = 1'b0;
    tx_ready = 1'b1;
    data_out = '0;
    #1;
    check_all_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1: payload command, busy while sreg_ctrl is busy
    exp_cmd_q.push_back('{cmd: 3'd1, data: 42'h0A5});
    push(4'h9);
    foreach (t1[i]) push(t1[i]);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = cmd_valid && cmd_ready;
    end
    check("t1_cmd_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_busy_wait", 64'({busy, cmd_valid}), 64'b10);
    end
    wait_idle(100, "t1");
    check("t1_busy_done", 64'(busy), 64'd0);

    // 2: header only, single pop, zero payload
    step();
    p0 = pops;
    exp_cmd_q.push_back('{cmd: 3'd3, data: '0});
    push(4'h3);
    wait_idle(100, "t2");
    check("t2_pops", 64'(pops - p0), 64'd1);

    // 3: readback with tx stall
    step();
    data_out = 42'h3FF_0000_1234;
    tx_ready = 1'b0;
    exp_cmd_q.push_back('{cmd: 3'd2, data: '0});
    foreach (t3[i]) exp_tx_q.push_back(t3[i]);
    push(4'h2);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = tx_valid;
    end
    check("t3_tx_seen", 64'(seen), 64'd1);
    repeat (5) @(negedge clk);
    check("t3_tx_held", 64'({tx_valid, tx_data}), 64'h13);
    step();
    tx_ready = 1'b1;
    wait_idle(100, "t3");
    check("t3_tx_valid_low", 64'(tx_valid), 64'd0);

    // 4: overflow on first payload nibble, remainder drained
    step();
    p0 = pops;
    exp_err_q.push_back(2'b01);
    push(4'h9);
    push(4'h4);
    for (int i = 0; i < 10; i++) push(4'(i));
    wait_idle(100, "t4");
    check("t4_pops", 64'(pops - p0), 64'd12);
    check("t4_fifo_empty", 64'(fifo_empty), 64'd1);
    check("t4_err_code_held", 64'(err_code), 64'd1);

    // 5: timeout mid-payload, then a clean packet
    step();
    exp_err_q.push_back(2'b10);
    push(4'h9);
    push(4'h0);
    push(4'h1);
    push(4'h2);
    wait_idle(5000, "t5");
    @(negedge clk);
    check("t5_idle", 64'({busy, err_code}), 64'h2);
    step();
    exp_cmd_q.push_back('{cmd: 3'd3, data: '0});
    push(4'h3);
    wait_idle(100, "t5b");

    // 6: asynchronous reset during payload, then a clean packet
    step();
    push(4'h9);
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    exp_cmd_q.push_back('{cmd: 3'd1, data: 42'h3FF_FFFF_FFFF});
    push(4'h9);
    push(4'h3);
    for (int i = 0; i < 10; i++) push(4'hF);
    wait_idle(100, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
